// File: rtl/seq_report_pkg.sv
// Shared constants and types for the sequence-detector UART reporter.
// Frame layout and the byte-level transmitter state encoding.
package seq_report_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  function automatic logic [7:0] frame_cksum(
    input logic [15:0] a,
    input logic [15:0] f,
    input logic [15:0] p
  );
    return a[15:8] ^ a[7:0] ^ f[15:8] ^ f[7:0] ^ p[15:8] ^ p[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter; done pulses in the last stop-bit cycle so the
// next byte can be chained with no idle gap.
module uart_tx_byte
  import seq_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_nx;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          w_tick;
  logic          w_go;

  assign w_tick = (r_timer == '0);
  assign tx     = r_tx;

  always_comb begin
    w_state_nx = r_state;
    done       = 1'b0;
    w_go       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_go = start;
        if (start) w_state_nx = START;
      end
      START: if (w_tick) w_state_nx = DATA;
      DATA:  if (w_tick && r_bit == 3'd7) w_state_nx = STOP;
      STOP: begin
        if (w_tick) begin
          done       = 1'b1;
          w_go       = start;
          w_state_nx = start ? START : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_timer <= T_LOAD;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      if (r_state == IDLE || w_tick) r_timer <= T_LOAD;
      else                           r_timer <= r_timer - 1'b1;
      if (w_go) begin
        r_shift <= data;
        r_tx    <= 1'b0;
        r_bit   <= 3'd0;
      end else if (w_tick) begin
        unique case (r_state)
          START: begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          DATA: begin
            if (r_bit == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/seq_uart_reporter.sv
// Decimates dclk, snapshots amp/freq/phase and sends them as an
// 8-byte UART frame (sync, six data bytes, XOR checksum).
module seq_uart_reporter
  import seq_report_pkg::*;
#(
  parameter int M            = 14,
  parameter int CLKS_PER_BIT = 868,
  parameter int DECIM        = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dclk,
  input  logic         en,
  input  logic [M-1:0] Vpos_amp,
  input  logic [15:0]  Vpos_freq,
  input  logic [15:0]  Vpos_phase,
  output logic         uart_tx,
  output logic         busy,
  output logic [7:0]   overrun_cnt
);

  logic        r_sync1, r_sync2, r_sync3;
  logic [15:0] r_dcnt;
  logic [15:0] r_amp, r_freq, r_phase;
  logic [2:0]  r_idx;
  logic        r_busy;
  logic [7:0]  r_ovr;
  logic        w_rise, w_wrap, w_trigger, w_accept;
  logic        w_done, w_last, w_start;
  logic [2:0]  w_sel;
  logic [7:0]  w_byte;

  assign w_rise    = r_sync2 & ~r_sync3;
  assign w_wrap    = (r_dcnt == 16'(DECIM - 1));
  assign w_trigger = en & w_rise & w_wrap;
  assign w_accept  = w_trigger & ~r_busy;
  assign w_last    = (r_idx == 3'(FRAME_BYTES - 1));
  assign w_start   = w_accept | (w_done & ~w_last);
  // on a chained start the mux must already present the next byte
  assign w_sel     = w_done ? r_idx + 3'd1 : r_idx;

  always_comb begin
    w_byte = SYNC_BYTE;
    unique case (w_sel)
      3'd0: w_byte = SYNC_BYTE;
      3'd1: w_byte = r_amp[15:8];
      3'd2: w_byte = r_amp[7:0];
      3'd3: w_byte = r_freq[15:8];
      3'd4: w_byte = r_freq[7:0];
      3'd5: w_byte = r_phase[15:8];
      3'd6: w_byte = r_phase[7:0];
      3'd7: w_byte = frame_cksum(r_amp, r_freq, r_phase);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_dcnt  <= 16'd0;
    end else begin
      r_sync1 <= dclk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (!en)         r_dcnt <= 16'd0;
      else if (w_rise) r_dcnt <= w_wrap ? 16'd0 : r_dcnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_amp   <= 16'd0;
      r_freq  <= 16'd0;
      r_phase <= 16'd0;
      r_idx   <= 3'd0;
      r_busy  <= 1'b0;
      r_ovr   <= 8'd0;
    end else begin
      if (w_accept) begin
        r_amp   <= 16'(Vpos_amp);
        r_freq  <= Vpos_freq;
        r_phase <= Vpos_phase;
        r_busy  <= 1'b1;
        r_idx   <= 3'd0;
      end else if (w_done) begin
        r_idx  <= w_last ? 3'd0 : r_idx + 3'd1;
        r_busy <= ~w_last;
      end
      if (w_trigger && r_busy && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(w_start),
    .data (w_byte),
    .tx   (uart_tx),
    .done (w_done)
  );

  assign busy        = r_busy;
  assign overrun_cnt = r_ovr;

endmodule
